// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//
// Shared types and helpers for the FIFO write-side arbiter slice.
//
// Contents:
//   arb_state_t        arbiter state (IDLE, BURST)
//   beat_cnt_width()   width of the per-burst beat counter for a given
//                      maximum burst length
//   DEFAULT_MAX_BURST  default burst limit used by the top level
//   DEFAULT_BEAT_CNT_W beat counter width for DEFAULT_MAX_BURST
//   rr_wrap()          modulo-NUM_REQ wrap for round-robin indices
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // The beat counter carries one extra bit above clog2(max_burst) so it can
   // hold the value reached after the final beat of a full-length burst.
   function automatic int beat_cnt_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   localparam int DEFAULT_MAX_BURST  = 4;
   localparam int DEFAULT_BEAT_CNT_W = beat_cnt_width(DEFAULT_MAX_BURST);

   // Wraps an index that is at most 2*num_req-2 back into 0..num_req-1.
   // Callers only ever add an offset smaller than num_req to a valid index,
   // so a single conditional subtract is enough.
   function automatic int rr_wrap(input int idx, input int num_req);
      if (idx >= num_req) begin
         return idx - num_req;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purely combinational round-robin picker. Starting at rr_ptr and moving
// upward (modulo NUM_REQ), returns the index of the first requester whose
// req bit is set.
//
// Ports:
//   req        in   NUM_REQ   request vector
//   rr_ptr     in   ID_WIDTH  highest-priority index for this pick
//   grant_idx  out  ID_WIDTH  chosen index (0 when no request is pending)
//   any_req    out  1         at least one req bit is set
// ---------------------------------------------------------------------------
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic [ID_WIDTH-1:0] grant_idx,
   output logic                any_req
);

   logic [ID_WIDTH-1:0] cand;

   // Scan from the lowest-priority offset down to offset 0 so that the last
   // match written, and therefore the winner, is the one closest to rr_ptr.
   always_comb begin
      grant_idx = '0;
      cand      = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = ID_WIDTH'(rr_wrap(int'(rr_ptr) + off, NUM_REQ));
         if (req[cand]) begin
            grant_idx = cand;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares one async-FIFO write port among NUM_REQ producers in the wr_clk
// domain. A producer is picked round-robin, then keeps the port until its
// burst ends (req_last, MAX_BURST beats, or it drops req), after which
// priority moves to the next index. The FIFO write strobe is gated with
// fifo_full, so the FIFO never sees a write while full.
//
// Ports:
//   wr_clk       in   1                   write-domain clock
//   rst          in   1                   synchronous active-high reset
//   arb_en       in   1                   allow new bursts to start
//   req          in   NUM_REQ             per-producer word valid
//   req_last     in   NUM_REQ             per-producer end of packet
//   req_data     in   NUM_REQ*DATA_WIDTH  packed producer words
//   ack          out  NUM_REQ             one-hot word accepted
//   fifo_full    in   1                   FIFO full flag
//   fifo_wr_en   out  1                   FIFO write strobe
//   fifo_wdata   out  DATA_WIDTH          FIFO write data
//   owner_valid  out  1                   a burst is in progress
//   owner_id     out  ID_WIDTH            index of the current owner
//   busy         out  1                   in a burst or any req pending
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = DEFAULT_MAX_BURST,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          wr_clk,
   input  logic                          rst,
   input  logic                          arb_en,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic                          owner_valid,
   output logic [ID_WIDTH-1:0]           owner_id,
   output logic                          busy
);

   localparam int              BEAT_W    = beat_cnt_width(MAX_BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [ID_WIDTH-1:0] owner_q;
   logic [ID_WIDTH-1:0] owner_d;
   logic [ID_WIDTH-1:0] rr_ptr_q;
   logic [ID_WIDTH-1:0] rr_ptr_d;
   logic [BEAT_W-1:0]   beat_cnt_q;
   logic [BEAT_W-1:0]   beat_cnt_d;

   logic [ID_WIDTH-1:0] grant_idx;
   logic                any_req;
   logic [ID_WIDTH-1:0] next_ptr;
   logic                owner_req;
   logic                owner_last;
   logic [DATA_WIDTH-1:0] word [NUM_REQ];

   // Unpack the flat data bus so the owner's word can be selected by index.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_pick (
      .req       (req),
      .rr_ptr    (rr_ptr_q),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign owner_req  = req[owner_q];
   assign owner_last = req_last[owner_q];
   assign next_ptr   = ID_WIDTH'(rr_wrap(int'(owner_q) + 1, NUM_REQ));

   // State register. Reset is sampled on the clock so the whole block stays
   // in the single wr_clk domain with no asynchronous paths.
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Next-state and output decode. IDLE spends exactly one cycle choosing an
   // owner and never transfers data. In BURST the owner's word is always on
   // fifo_wdata and is strobed only when the FIFO has room. The write is also
   // suppressed while rst is high, so a burst interrupted by reset writes
   // nothing in the reset cycle and the producer keeps that word.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      ack        = '0;
      fifo_wr_en = 1'b0;
      fifo_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (arb_en && any_req) begin
               owner_d    = grant_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end

         BURST: begin
            fifo_wdata   = word[owner_q];
            fifo_wr_en   = owner_req && !fifo_full && !rst;
            ack[owner_q] = fifo_wr_en;
            if (fifo_wr_en) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (owner_last || (beat_cnt_q == LAST_BEAT)) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
               end
            end else if (!owner_req) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign owner_valid = (state_q == BURST);
   assign owner_id    = owner_q;
   assign busy        = (state_q == BURST) || any_req;

endmodule
